instruction_encoder: RTL

//  Encoder/loader side of the MIPS instruction format consumed by the core's decoder.

---
 rtl/instruction_encoder.sv | 99 +++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and streams them into
// instruction memory at consecutive word addresses, one write per accepted handshake.
module instruction_encoder #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] count_d;
  logic            err_d;
  logic            handshake;
  logic            legal;
  logic [31:0]     enc_word;

  assign in_ready  = (state_q == LOAD) && (count < DEPTH_C);
  assign handshake = in_valid && in_ready;
  assign legal     = handshake && (op_sel != 3'd7);
  assign busy      = (state_q != IDLE);
  assign full      = (state_q == FULL);

  always_comb begin
    enc_word = 32'h0;
    case (op_sel)
      3'd0: enc_word = {6'h00, rs, rt, rd, shamt, 6'h20};
      3'd1: enc_word = {6'h00, rs, rt, rd, shamt, 6'h21};
      3'd2: enc_word = {6'h00, rs, rt, rd, shamt, 6'h22};
      3'd3: enc_word = {6'h00, rs, rt, rd, shamt, 6'h24};
      3'd4: enc_word = {6'h08, rs, rt, imm};
      3'd5: enc_word = {6'h23, rs, rt, imm};
      3'd6: enc_word = {6'h2B, rs, rt, imm};
      default: enc_word = 32'h0;
    endcase
  end

  // start overrides stop; a handshake in the same cycle still counts against the old state
  always_comb begin
    state_d = state_q;
    count_d = count;
    err_d   = err;
    if (handshake && !legal) err_d = 1'b1;
    if (legal) begin
      count_d = count + 1'b1;
      if (count_d == DEPTH_C) state_d = FULL;
    end
    if (stop) state_d = IDLE;
    if (start) begin
      state_d = LOAD;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      err     <= err_d;
      imem_we <= legal;
      if (legal) begin
        imem_addr  <= BASE_C + count[ADDR_W-1:0];
        imem_wdata <= enc_word;
      end
    end
  end

endmodule
